// File: rtl/flatten_layer2_pkg.sv
// Shared constants and state encoding for the layer-2 flatten stage.
package flatten_layer2_pkg;

  localparam int unsigned CHANNELS  = 12;
  localparam int unsigned POSITIONS = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FLAT_LEN  = CHANNELS * POSITIONS;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned POS_W     = $clog2(POSITIONS + 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/flatten_buffer.sv
// Flat register file: one column write (all channels at one position), one read port.
module flatten_buffer
  import flatten_layer2_pkg::*;
#(
  parameter int unsigned CHANNELS  = flatten_layer2_pkg::CHANNELS,
  parameter int unsigned POSITIONS = flatten_layer2_pkg::POSITIONS,
  parameter int unsigned DATA_W    = flatten_layer2_pkg::DATA_W
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_clr,
  input  logic                             i_wr_en,
  input  logic [POS_W-1:0]                 i_wr_pos,
  input  logic [CHANNELS-1:0][DATA_W-1:0]  i_wr_data,
  input  logic [IDX_W-1:0]                 i_rd_addr,
  output logic [DATA_W-1:0]                o_rd_data_c
);

  localparam int unsigned N_WORDS = CHANNELS * POSITIONS;
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(N_WORDS - 1);

  logic [DATA_W-1:0] w_mem [N_WORDS];

  // Entry e belongs to channel e/POSITIONS, position e%POSITIONS (channel-major).
  for (genvar e = 0; e < N_WORDS; e++) begin : g_ent
    localparam int unsigned CH = e / POSITIONS;
    localparam int unsigned PS = e % POSITIONS;
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
        r_word <= '0;
      end else if (i_wr_en && (i_wr_pos == POS_W'(PS))) begin
        r_word <= i_wr_data[CH];
      end
    end

    assign w_mem[e] = r_word;
  end

  assign o_rd_data_c = (i_rd_addr <= LAST_ADDR) ? w_mem[i_rd_addr] : '0;

endmodule

// File: rtl/flatten_layer2.sv
// Collects 12-channel pooled beats into a channel-major buffer, then serializes it.
module flatten_layer2
  import flatten_layer2_pkg::*;
#(
  parameter int unsigned CHANNELS  = flatten_layer2_pkg::CHANNELS,
  parameter int unsigned POSITIONS = flatten_layer2_pkg::POSITIONS,
  parameter int unsigned DATA_W    = flatten_layer2_pkg::DATA_W
) (
  input  logic              Clock,
  input  logic              Input_Reset,
  input  logic [DATA_W-1:0] Input_Pixel_1,
  input  logic [DATA_W-1:0] Input_Pixel_2,
  input  logic [DATA_W-1:0] Input_Pixel_3,
  input  logic [DATA_W-1:0] Input_Pixel_4,
  input  logic [DATA_W-1:0] Input_Pixel_5,
  input  logic [DATA_W-1:0] Input_Pixel_6,
  input  logic [DATA_W-1:0] Input_Pixel_7,
  input  logic [DATA_W-1:0] Input_Pixel_8,
  input  logic [DATA_W-1:0] Input_Pixel_9,
  input  logic [DATA_W-1:0] Input_Pixel_10,
  input  logic [DATA_W-1:0] Input_Pixel_11,
  input  logic [DATA_W-1:0] Input_Pixel_12,
  input  logic              Input_Valid,
  input  logic              Input_Finish,
  input  logic              Output_Ready,
  output logic [DATA_W-1:0] Output_Pixel,
  output logic [7:0]        Output_Index,
  output logic              Output_Valid,
  output logic              Output_Finish,
  output logic              Busy,
  output logic              Overflow
);

  localparam int unsigned N_WORDS = CHANNELS * POSITIONS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [POS_W-1:0] POS_FULL = POS_W'(POSITIONS);

  state_t                          r_state;
  logic [POS_W-1:0]                r_pos;
  logic [IDX_W-1:0]                r_idx;
  logic [DATA_W-1:0]               r_pixel;
  logic [IDX_W-1:0]                r_index;
  logic                            r_valid;
  logic                            r_finish;
  logic                            r_busy;
  logic                            r_overflow;

  logic [CHANNELS-1:0][DATA_W-1:0] w_pix;
  logic                            w_wr_en;
  logic                            w_accept;
  logic [IDX_W-1:0]                w_rd_addr;
  logic [DATA_W-1:0]               w_rd_data;
  logic                            w_clr;

  assign w_pix = {Input_Pixel_12, Input_Pixel_11, Input_Pixel_10, Input_Pixel_9,
                  Input_Pixel_8,  Input_Pixel_7,  Input_Pixel_6,  Input_Pixel_5,
                  Input_Pixel_4,  Input_Pixel_3,  Input_Pixel_2,  Input_Pixel_1};

  assign w_wr_en  = (r_state == ST_COLLECT) && Input_Valid && (r_pos < POS_FULL);
  assign w_accept = (r_state == ST_DRAIN) && r_valid && Output_Ready;
  assign w_clr    = (r_state == ST_DONE);

  // Read one word ahead so the output register loads the next word on acceptance.
  assign w_rd_addr = ((r_state == ST_DRAIN) && (r_idx != LAST_IDX)) ? r_idx + IDX_W'(1) : '0;

  flatten_buffer #(
    .CHANNELS  (CHANNELS),
    .POSITIONS (POSITIONS),
    .DATA_W    (DATA_W)
  ) u_buffer (
    .i_clk       (Clock),
    .i_rst       (Input_Reset),
    .i_clr       (w_clr),
    .i_wr_en     (w_wr_en),
    .i_wr_pos    (r_pos),
    .i_wr_data   (w_pix),
    .i_rd_addr   (w_rd_addr),
    .o_rd_data_c (w_rd_data)
  );

  always_ff @(posedge Clock) begin
    if (Input_Reset) begin
      r_state    <= ST_COLLECT;
      r_pos      <= '0;
      r_idx      <= '0;
      r_pixel    <= '0;
      r_index    <= '0;
      r_valid    <= 1'b0;
      r_finish   <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_wr_en) begin
            r_pos <= r_pos + POS_W'(1);
          end
          if (Input_Valid && !w_wr_en) begin
            r_overflow <= 1'b1;
          end
          if (Input_Finish) begin
            r_state <= ST_DRAIN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_index <= '0;
            // Word 0 may be written on this very edge; forward it past the buffer.
            r_pixel <= (w_wr_en && (r_pos == '0)) ? w_pix[0] : w_rd_data;
          end
        end
        ST_DRAIN: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_state  <= ST_DONE;
              r_valid  <= 1'b0;
              r_busy   <= 1'b0;
              r_finish <= 1'b1;
              r_pixel  <= '0;
              r_index  <= '0;
              r_idx    <= '0;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_index <= r_idx + IDX_W'(1);
              r_pixel <= w_rd_data;
            end
          end
        end
        ST_DONE: begin
          r_finish <= 1'b0;
          r_state  <= ST_COLLECT;
          r_pos    <= '0;
          r_idx    <= '0;
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign Output_Pixel  = r_pixel;
  assign Output_Index  = r_index;
  assign Output_Valid  = r_valid;
  assign Output_Finish = r_finish;
  assign Busy          = r_busy;
  assign Overflow      = r_overflow;

endmodule

// File: tb/tb_flatten_layer2.sv
// Randomized bench for flatten_layer2 against a flat-array reference of the frame.
module tb_flatten_layer2;

  localparam int NCH  = 12;
  localparam int NPOS = 16;
  localparam int NW   = NCH * NPOS;

  logic        Clock = 1'b0;
  logic        Input_Reset = 1'b0;
  logic [15:0] pix [NCH];
  logic        Input_Valid = 1'b0;
  logic        Input_Finish = 1'b0;
  logic        Output_Ready = 1'b0;
  logic [15:0] Output_Pixel;
  logic [7:0]  Output_Index;
  logic        Output_Valid;
  logic        Output_Finish;
  logic        Busy;
  logic        Overflow;

  logic [15:0] model [NW];
  logic [15:0] cap   [NW];
  bit          exp_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  flatten_layer2 dut (
    .Clock          (Clock),
    .Input_Reset    (Input_Reset),
    .Input_Pixel_1  (pix[0]),
    .Input_Pixel_2  (pix[1]),
    .Input_Pixel_3  (pix[2]),
    .Input_Pixel_4  (pix[3]),
    .Input_Pixel_5  (pix[4]),
    .Input_Pixel_6  (pix[5]),
    .Input_Pixel_7  (pix[6]),
    .Input_Pixel_8  (pix[7]),
    .Input_Pixel_9  (pix[8]),
    .Input_Pixel_10 (pix[9]),
    .Input_Pixel_11 (pix[10]),
    .Input_Pixel_12 (pix[11]),
    .Input_Valid    (Input_Valid),
    .Input_Finish   (Input_Finish),
    .Output_Ready   (Output_Ready),
    .Output_Pixel   (Output_Pixel),
    .Output_Index   (Output_Index),
    .Output_Valid   (Output_Valid),
    .Output_Finish  (Output_Finish),
    .Busy           (Busy),
    .Overflow       (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic do_reset();
    @(negedge Clock);
    Input_Reset  = 1'b1;
    Input_Valid  = 1'b0;
    Input_Finish = 1'b0;
    Output_Ready = 1'b0;
    for (int c = 0; c < NCH; c++) pix[c] = '0;
    repeat (2) @(negedge Clock);
    Input_Reset = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // Drive n beats (pattern: ch c -> c*256+pos, 1-based c; else random) then a Finish pulse.
  task automatic send_frame(input int n, input bit pattern, input bit finish_on_last);
    logic [15:0] v;
    for (int i = 0; i < NW; i++) model[i] = '0;
    for (int b = 0; b < n; b++) begin
      @(negedge Clock);
      Input_Valid  = 1'b1;
      Input_Finish = finish_on_last && (b == n - 1);
      for (int c = 0; c < NCH; c++) begin
        v = pattern ? 16'((c + 1) * 256 + b) : 16'($urandom);
        pix[c] = v;
        if (b < NPOS) model[c * NPOS + b] = v;
      end
      if (b >= NPOS) exp_ovf = 1'b1;
    end
    @(negedge Clock);
    Input_Valid = 1'b0;
    if (!finish_on_last) begin
      Input_Finish = 1'b1;
      @(negedge Clock);
    end
    Input_Finish = 1'b0;
  endtask

  // rmode 0: ready high, 1: ready toggles from 1, 2: random ready plus noise on inputs.
  task automatic drain_check(input string name, input int rmode, input int exp_cyc);
    int k = 0, vcyc = 0, bad = 0, busy_bad = 0, guard = 0, bad_k = -1;
    bit fin = 1'b0;
    bit r;
    n_tests++;
    if (Output_Valid !== 1'b1 || Output_Index !== 8'd0) begin
      n_fail++;
      $display("FAIL %s first_word: valid=%0b index=%0d, required valid=1 index=0",
               name, Output_Valid, Output_Index);
    end
    while (!fin && guard < 2000) begin
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (vcyc % 2 == 0) : 1'($urandom);
      Output_Ready = r;
      if (rmode == 2) begin
        Input_Valid  = 1'($urandom);
        Input_Finish = 1'($urandom);
        for (int c = 0; c < NCH; c++) pix[c] = 16'($urandom);
      end
      if (Output_Valid) begin
        vcyc++;
        if (Busy !== 1'b1) busy_bad++;
        if (r) begin
          if (k < NW) begin
            cap[k] = Output_Pixel;
            if (Output_Index !== 8'(k) || Output_Pixel !== model[k]) begin
              bad++;
              if (bad_k < 0) bad_k = k;
            end
          end else begin
            bad++;
          end
          k++;
        end
      end
      if (Output_Finish === 1'b1) fin = 1'b1;
      @(negedge Clock);
      guard++;
    end
    Input_Valid  = 1'b0;
    Input_Finish = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s finish_timeout: no Output_Finish within %0d cycles", name, guard);
    end
    n_tests++;
    if (k != NW) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d, required %0d", name, k, NW);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s words: %0d wrong, first at k=%0d (required 0x%04h)",
               name, bad, bad_k, (bad_k >= 0) ? model[bad_k] : 16'h0);
    end
    n_tests++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy: low on %0d drain cycles, required 0", name, busy_bad);
    end
    n_tests++;
    if (Output_Finish !== 1'b0 || Output_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s finish_pulse: finish=%0b valid=%0b after DONE, required 0 0",
               name, Output_Finish, Output_Valid);
    end
    if (exp_cyc >= 0) begin
      n_tests++;
      if (vcyc != exp_cyc) begin
        n_fail++;
        $display("FAIL %s drain_cycles: got %0d, required %0d", name, vcyc, exp_cyc);
      end
    end
    n_tests++;
    if (Overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s overflow: got %0b, required %0b", name, Overflow, exp_ovf);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({Output_Valid, Output_Finish, Busy, Overflow} !== 4'b0000 ||
        Output_Pixel !== 16'h0 || Output_Index !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b fin=%0b busy=%0b ovf=%0b pix=0x%04h idx=%0d, required all 0",
               Output_Valid, Output_Finish, Busy, Overflow, Output_Pixel, Output_Index);
    end
  endtask

  task automatic test_full_frame();
    send_frame(16, 1'b1, 1'b0);
    drain_check("full_frame", 0, NW);
  endtask

  task automatic test_ready_toggle();
    send_frame(16, 1'b0, 1'b0);
    drain_check("ready_toggle", 1, 2 * NW - 1);
  endtask

  task automatic test_short_frame();
    send_frame(10, 1'b0, 1'b0);
    drain_check("short_frame", 0, NW);
  endtask

  task automatic test_overflow();
    do_reset();
    send_frame(17, 1'b1, 1'b0);
    n_tests++;
    if (Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %0b, required 1", Overflow);
    end
    drain_check("overflow", 0, NW);
  endtask

  task automatic test_valid_finish();
    do_reset();
    send_frame(16, 1'b1, 1'b1);
    drain_check("valid_finish", 0, NW);
    n_tests++;
    if (cap[15] !== 16'h010F) begin
      n_fail++;
      $display("FAIL valid_finish_word15: got 0x%04h, required 0x010F", cap[15]);
    end
  endtask

  task automatic test_single_beat();
    send_frame(1, 1'b0, 1'b1);
    drain_check("single_beat", 0, NW);
  endtask

  task automatic test_reset_mid_drain();
    int g = 0;
    send_frame(16, 1'b0, 1'b0);
    Output_Ready = 1'b1;
    while (Output_Index !== 8'd50 && g < 500) begin
      @(negedge Clock);
      g++;
    end
    Input_Reset = 1'b1;
    @(negedge Clock);
    n_tests++;
    if (g >= 500 || Output_Valid !== 1'b0 || Busy !== 1'b0 || Output_Index !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_drain_reset: valid=%0b busy=%0b idx=%0d waited=%0d, required 0 0 0",
               Output_Valid, Busy, Output_Index, g);
    end
    Input_Reset = 1'b0;
    exp_ovf = 1'b0;
    send_frame(16, 1'b0, 1'b0);
    drain_check("after_reset", 0, NW);
  endtask

  task automatic test_back_to_back();
    send_frame(16, 1'b0, 1'b0);
    drain_check("b2b_first", 2, -1);
    send_frame(5, 1'b0, 1'b0);
    drain_check("b2b_second", 0, NW);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) pix[c] = '0;
    exp_ovf = 1'b0;
    test_reset();
    test_full_frame();
    test_ready_toggle();
    test_short_frame();
    test_overflow();
    test_valid_finish();
    test_single_beat();
    test_reset_mid_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
